prog_ctr_seq: RTL and testbench

Parametrised program counter with run-control sequencer and hardware return-address stack, forming the first half of the fetch stage. It generalises the fixed 10-bit counter: configurable width and start address, Start/Halt handshake with explicit run states, conditional relative branches with signed offsets, and call/return through an internal LIFO with overflow/underflow fault detection. It drives the instruction-memory address and takes branch controls from decode and the flag from the ALU.

---
 rtl/prog_ctr_seq_pkg.sv | 22 ++
 rtl/prog_ctr_seq_if.sv | 36 +++
 rtl/prog_ctr_seq_ret_stack.sv | 74 +++++++
 rtl/prog_ctr_seq.sv | 116 +++++++++++
 tb/tb_prog_ctr_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/prog_ctr_seq_pkg.sv
// Shared types for the program-counter sequencer.
//   state_e  : run-control states of the sequencer
//   pc_sel_e : source selected for the next program-counter value
package prog_ctr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StFault
    } state_e;

    typedef enum logic [2:0] {
        SelHold,
        SelInc,
        SelAbs,
        SelRel,
        SelCall,
        SelRet
    } pc_sel_e;

endpackage

// File: rtl/prog_ctr_seq_if.sv
// Control/status bundle between the decode/ALU side and the program-counter sequencer.
//   master : drives Start, Halt, Stall, branch/call/return controls, ALU_flag, Target;
//            observes ProgCtr, Running, Done, Fault, StackDepth
//   slave  : the sequencer side (directions reversed)
interface prog_ctr_seq_if #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned RET_DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(RET_DEPTH + 1);

    logic               Start;
    logic               Halt;
    logic               Stall;
    logic               BranchAbsEn;
    logic               BranchRelEn;
    logic               ALU_flag;
    logic               CallEn;
    logic               RetEn;
    logic [PC_W-1:0]    Target;
    logic [PC_W-1:0]    ProgCtr;
    logic               Running;
    logic               Done;
    logic               Fault;
    logic [DEPTH_W-1:0] StackDepth;

    modport master (
        output Start, Halt, Stall, BranchAbsEn, BranchRelEn, ALU_flag, CallEn, RetEn, Target,
        input  ProgCtr, Running, Done, Fault, StackDepth
    );

    modport slave (
        input  Start, Halt, Stall, BranchAbsEn, BranchRelEn, ALU_flag, CallEn, RetEn, Target,
        output ProgCtr, Running, Done, Fault, StackDepth
    );

endinterface

// File: rtl/prog_ctr_seq_ret_stack.sv
// Return-address LIFO, RET_DEPTH entries of PC_W bits.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush (takes precedence over push/pop)
//   push_i        : write push_data_i on top (ignored when full)
//   pop_i         : discard top entry (ignored when empty)
//   top_o         : most recently pushed entry (zero when empty)
//   depth_o       : number of valid entries
//   full_o/empty_o: depth at RET_DEPTH / zero
module ret_stack #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned RET_DEPTH = 4,
    localparam int unsigned DEPTH_W  = $clog2(RET_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [PC_W-1:0]    push_data_i,
    output logic [PC_W-1:0]    top_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [PC_W-1:0]    mem_q [RET_DEPTH];
    logic [PC_W-1:0]    mem_d [RET_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;

    assign full_o  = (depth_q == DEPTH_W'(RET_DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    // Entries are selected by comparison rather than by indexing with depth_q, whose
    // width exceeds the array index width.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < RET_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) begin
                top_o = mem_q[i];
            end
        end
    end

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (clear_i) begin
            depth_d = '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < RET_DEPTH; i++) begin
                if (DEPTH_W'(i) == depth_q) begin
                    mem_d[i] = push_data_i;
                end
            end
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
            for (int i = 0; i < RET_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/prog_ctr_seq.sv
// Program counter with Start/Halt run control, absolute/relative branches and
// call/return through a hardware return-address stack.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : controls in (Start, Halt, Stall, BranchAbsEn, BranchRelEn, ALU_flag,
//                  CallEn, RetEn, Target); registered status out (ProgCtr, Running,
//                  Done, Fault, StackDepth)
// The interface instance must be parameterised with the same PC_W and RET_DEPTH.
module prog_ctr_seq
    import prog_ctr_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned RET_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    prog_ctr_seq_if.slave bus
);

    localparam int unsigned DEPTH_W = $clog2(RET_DEPTH + 1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    pc_sel_e         pc_sel;
    logic            start_load;

    logic [PC_W-1:0]    stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;

    ret_stack #(
        .PC_W      (PC_W),
        .RET_DEPTH (RET_DEPTH)
    ) u_ret_stack (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .clear_i     (start_load),
        .push_i      (pc_sel == SelCall),
        .pop_i       (pc_sel == SelRet),
        .push_data_i (pc_q + PC_W'(1)),
        .top_o       (stk_top),
        .depth_o     (stk_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    // Run control and next-PC source selection, highest priority first.
    always_comb begin
        state_d    = state_q;
        pc_sel     = SelHold;
        start_load = 1'b0;
        unique case (state_q)
            StIdle, StDone, StFault: begin
                if (bus.Start) begin
                    state_d    = StRun;
                    start_load = 1'b1;
                end
            end
            StRun: begin
                if (!bus.Stall) begin
                    if (bus.Halt) begin
                        state_d = StDone;
                    end else if (bus.RetEn) begin
                        if (stk_empty) state_d = StFault;
                        else           pc_sel  = SelRet;
                    end else if (bus.CallEn) begin
                        if (stk_full) state_d = StFault;
                        else          pc_sel  = SelCall;
                    end else if (bus.BranchAbsEn) begin
                        pc_sel = SelAbs;
                    end else if (bus.BranchRelEn && bus.ALU_flag) begin
                        pc_sel = SelRel;
                    end else begin
                        pc_sel = SelInc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Plain PC_W-bit addition gives the modulo-2^PC_W wrap and the signed offset for free.
    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            SelHold: pc_d = pc_q;
            SelInc:  pc_d = pc_q + PC_W'(1);
            SelAbs:  pc_d = bus.Target;
            SelRel:  pc_d = pc_q + bus.Target;
            SelCall: pc_d = bus.Target;
            SelRet:  pc_d = stk_top;
            default: pc_d = pc_q;
        endcase
        if (start_load) begin
            pc_d = PC_W'(START_ADDR);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.ProgCtr    = pc_q;
    assign bus.Running    = (state_q == StRun);
    assign bus.Done       = (state_q == StDone);
    assign bus.Fault      = (state_q == StFault);
    assign bus.StackDepth = stk_depth;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed bench for prog_ctr_seq (PC_W=10, RET_DEPTH=4, START_ADDR=0).
// Each check compares a 16-bit snapshot {ProgCtr, Running, Done, Fault, StackDepth}.
module tb_prog_ctr_seq;

    logic Clk;
    logic Reset_n;
    int   n_vec;
    int   n_err;
    logic [15:0] got;
    logic [15:0] want;

    prog_ctr_seq_if #(.PC_W(10), .RET_DEPTH(4)) bus ();

    prog_ctr_seq #(
        .PC_W       (10),
        .RET_DEPTH  (4),
        .START_ADDR (0)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] snap();
        return {bus.ProgCtr, bus.Running, bus.Done, bus.Fault, bus.StackDepth};
    endfunction

    task automatic clear_ctrl();
        bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.BranchAbsEn = 0;
        bus.BranchRelEn = 0; bus.ALU_flag = 0; bus.CallEn = 0; bus.RetEn = 0;
        bus.Target = '0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_ctrl();
        Reset_n = 0;
        repeat (3) @(posedge Clk);
        #1;
        got = snap(); want = {10'd0, 3'b000, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reset_state: got %h want %h", got, want); end
        Reset_n = 1;
        step(); step();
        got = snap(); want = {10'd0, 3'b000, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL idle_no_start: got %h want %h", got, want); end
    endtask

    task automatic test_start_count();
        bus.Start = 1; step(); bus.Start = 0;
        got = snap(); want = {10'd0, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL start: got %h want %h", got, want); end
        for (int i = 1; i <= 3; i++) begin
            step();
            got = snap(); want = {10'(i), 3'b100, 3'd0}; n_vec++;
            if (got !== want) begin n_err++; $display("FAIL count_%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_branch();
        step(); step();
        got = snap(); want = {10'd5, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reach_5: got %h want %h", got, want); end
        bus.BranchRelEn = 1; bus.Target = 10'h3FE; bus.ALU_flag = 1; step(); clear_ctrl();
        got = snap(); want = {10'd3, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rel_taken: got %h want %h", got, want); end
        step(); step();
        bus.BranchRelEn = 1; bus.Target = 10'h3FE; bus.ALU_flag = 0; step(); clear_ctrl();
        got = snap(); want = {10'd6, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rel_not_taken: got %h want %h", got, want); end
        bus.BranchAbsEn = 1; bus.Target = 10'h3FF; step(); clear_ctrl();
        got = snap(); want = {10'h3FF, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL abs_3ff: got %h want %h", got, want); end
        step();
        got = snap(); want = {10'h000, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL wrap_0: got %h want %h", got, want); end
    endtask

    task automatic test_call_wrap();
        bus.BranchAbsEn = 1; bus.Target = 10'h3FF; step(); clear_ctrl();
        bus.CallEn = 1; bus.Target = 10'd7; step(); clear_ctrl();
        got = snap(); want = {10'd7, 3'b100, 3'd1}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL call_from_3ff: got %h want %h", got, want); end
        bus.RetEn = 1; step(); clear_ctrl();
        got = snap(); want = {10'd0, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL ret_wrapped: got %h want %h", got, want); end
    endtask

    task automatic test_call_ret();
        repeat (8) step();
        got = snap(); want = {10'd8, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reach_8: got %h want %h", got, want); end
        bus.CallEn = 1; bus.Target = 10'd100; step(); clear_ctrl();
        got = snap(); want = {10'd100, 3'b100, 3'd1}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL call_100: got %h want %h", got, want); end
        bus.RetEn = 1; step(); clear_ctrl();
        got = snap(); want = {10'd9, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL ret_9: got %h want %h", got, want); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            bus.CallEn = 1; bus.Target = 10'(200 + i); step();
            got = snap(); want = {10'(200 + i), 3'b100, 3'(i + 1)}; n_vec++;
            if (got !== want) begin n_err++; $display("FAIL nest_call_%0d: got %h want %h", i, got, want); end
        end
        bus.CallEn = 1; bus.Target = 10'd204; step(); clear_ctrl();
        got = snap(); want = {10'd203, 3'b001, 3'd4}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL overflow: got %h want %h", got, want); end
        bus.RetEn = 1; step(); clear_ctrl(); step();
        got = snap(); want = {10'd203, 3'b001, 3'd4}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fault_frozen: got %h want %h", got, want); end
        bus.Start = 1; step(); bus.Start = 0;
        got = snap(); want = {10'd0, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL restart_from_fault: got %h want %h", got, want); end
    endtask

    task automatic test_underflow_stall();
        bus.RetEn = 1; step(); clear_ctrl();
        got = snap(); want = {10'd0, 3'b001, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL underflow: got %h want %h", got, want); end
        bus.Start = 1; step(); bus.Start = 0;
        step();
        bus.Stall = 1; bus.CallEn = 1; bus.Target = 10'd50; step();
        got = snap(); want = {10'd1, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL stall_call: got %h want %h", got, want); end
        bus.Halt = 1; step(); clear_ctrl();
        got = snap(); want = {10'd1, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL stall_halt: got %h want %h", got, want); end
        step();
        got = snap(); want = {10'd2, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL after_stall: got %h want %h", got, want); end
    endtask

    task automatic test_halt_call();
        bus.CallEn = 1; bus.Target = 10'd40; step(); clear_ctrl();
        bus.Halt = 1; bus.CallEn = 1; bus.Target = 10'd60; step(); clear_ctrl();
        got = snap(); want = {10'd40, 3'b010, 3'd1}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL halt_over_call: got %h want %h", got, want); end
        step();
        got = snap(); want = {10'd40, 3'b010, 3'd1}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL done_frozen: got %h want %h", got, want); end
        bus.Start = 1; step(); bus.Start = 0;
        got = snap(); want = {10'd0, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL restart_from_done: got %h want %h", got, want); end
    endtask

    task automatic test_start_in_run();
        step();
        bus.Start = 1; step(); bus.Start = 0;
        got = snap(); want = {10'd2, 3'b100, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL start_ignored_in_run: got %h want %h", got, want); end
    endtask

    task automatic test_reset_mid_run();
        bus.CallEn = 1; bus.Target = 10'd77; step(); clear_ctrl();
        #2 Reset_n = 0;
        #1;
        got = snap(); want = {10'd0, 3'b000, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL async_reset: got %h want %h", got, want); end
        step();
        Reset_n = 1;
        step();
        got = snap(); want = {10'd0, 3'b000, 3'd0}; n_vec++;
        if (got !== want) begin n_err++; $display("FAIL idle_after_reset: got %h want %h", got, want); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_start_count();
        test_branch();
        test_call_wrap();
        test_call_ret();
        test_overflow();
        test_underflow_stall();
        test_halt_call();
        test_start_in_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
